vga_plot_arbiter: RTL and testbench

- Shares the single VGA adapter plot port (x, y, colour, plot) between multiple pixel-drawing clients: start-screen drawer, screen resetter, note-block drawer, scanner.
- Grants one client at a time for a whole burst (a region or frame), using round-robin. Output muxing is registered, which removes the combinational per-state mux that currently sits in the top level.
- Sits between the drawing modules and vga_adapter. The top level drives its outputs straight into .x/.y/.colour/.plot.

---
 rtl/vga_plot_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single VGA plot port: one client holds the port for a whole burst,
// pixel outputs are registered. Define PLOT_ARB_TIMEOUT_EN to revoke grants from stalled clients.
module vga_plot_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int X_W         = 8,
    parameter int Y_W         = 8,
    parameter int COLOUR_W    = 24,
    parameter int TIMEOUT     = 255
) (
    input  logic                            CLOCK_50,
    input  logic                            resetn,
    input  logic [NUM_CLIENTS-1:0]          req_valid,
    input  logic [NUM_CLIENTS-1:0]          req_last,
    input  logic [NUM_CLIENTS*X_W-1:0]      req_x,
    input  logic [NUM_CLIENTS*Y_W-1:0]      req_y,
    input  logic [NUM_CLIENTS*COLOUR_W-1:0] req_colour,
    output logic [NUM_CLIENTS-1:0]          req_ready,
    output logic [NUM_CLIENTS-1:0]          burst_done,
    output logic [X_W-1:0]                  screenX,
    output logic [Y_W-1:0]                  screenY,
    output logic [COLOUR_W-1:0]             colour,
    output logic                            plotWriteEnable,
    output logic                            busy,
    output logic [2:0]                      grant_id
);
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t                  r_state, w_state_nxt;
    logic [NUM_CLIENTS-1:0]  r_ready, w_ready_nxt, r_done, w_done_nxt, w_acc;
    logic                    r_busy, w_busy_nxt, r_plot;
    logic [2:0]              r_grant_id, w_gid_nxt, r_rr_ptr, w_rr_nxt, w_sel;
    logic                    w_found, w_accept, w_last, w_revoke;
    logic [X_W-1:0]          r_x, w_x;
    logic [Y_W-1:0]          r_y, w_y;
    logic [COLOUR_W-1:0]     r_col, w_col;

    if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || TIMEOUT < 1) begin : g_param_check
        $error("vga_plot_arbiter: NUM_CLIENTS must be 2..8 and TIMEOUT >= 1");
    end

    assign w_acc    = r_ready & req_valid;
    assign w_accept = |w_acc;
    assign w_last   = |(w_acc & req_last);
    assign w_x      = req_x[r_grant_id*X_W +: X_W];
    assign w_y      = req_y[r_grant_id*Y_W +: Y_W];
    assign w_col    = req_colour[r_grant_id*COLOUR_W +: COLOUR_W];

    // Round-robin pick: first requester strictly after the last finished client
    always_comb begin
        w_sel   = 3'd0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NUM_CLIENTS]) begin
                w_sel   = 3'((int'(r_rr_ptr) + k) % NUM_CLIENTS);
                w_found = 1'b1;
            end else begin
            end
        end
    end

`ifdef PLOT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_stall_cnt;

    // Count consecutive bubbles of the current grant; any accepted pixel or new grant restarts it
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_GRANT && !w_accept) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= '0;
        end
    end

    assign w_revoke = (r_state == S_GRANT) && !w_accept && (r_stall_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_revoke = 1'b0;
`endif

    // Next-state and next-grant decode
    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = r_ready;
        w_busy_nxt  = r_busy;
        w_gid_nxt   = r_grant_id;
        w_rr_nxt    = r_rr_ptr;
        w_done_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_ready_nxt = NUM_CLIENTS'(1) << w_sel;
                    w_busy_nxt  = 1'b1;
                    w_gid_nxt   = w_sel;
                end else begin
                end
            end
            S_GRANT: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_rr_nxt    = r_grant_id;
                    w_done_nxt  = r_ready;
                end else if (w_revoke) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_rr_nxt    = r_grant_id;
                end else begin
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Arbiter state registers; rr_ptr resets to the top index so client 0 wins first
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_ready    <= '0;
            r_busy     <= 1'b0;
            r_grant_id <= 3'd0;
            r_rr_ptr   <= 3'(NUM_CLIENTS - 1);
            r_done     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_grant_id <= w_gid_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Registered plot port; coordinates and colour hold when nothing is accepted
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_plot <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_col  <= '0;
        end else begin
            r_plot <= w_accept;
            if (w_accept) begin
                r_x   <= w_x;
                r_y   <= w_y;
                r_col <= w_col;
            end
        end
    end

    assign req_ready       = r_ready;
    assign burst_done      = r_done;
    assign screenX         = r_x;
    assign screenY         = r_y;
    assign colour          = r_col;
    assign plotWriteEnable = r_plot;
    assign busy            = r_busy;
    assign grant_id        = r_grant_id;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: per-cycle vector table for a single burst, then client models
// feeding a scoreboard for contention, fairness, bubble, reset and stall sequences.
module tb_vga_plot_arbiter;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 8;
    localparam int CW = 24;
    localparam int TO = 8;
`ifdef PLOT_ARB_TIMEOUT_EN
    localparam int STALL = 20;
`else
    localparam int STALL = 1000;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic [N-1:0]    req_valid, req_last, req_ready, burst_done;
    logic [N*XW-1:0] req_x;
    logic [N*YW-1:0] req_y;
    logic [N*CW-1:0] req_colour;
    logic [XW-1:0]   screenX;
    logic [YW-1:0]   screenY;
    logic [CW-1:0]   colour;
    logic            plot, busy;
    logic [2:0]      grant_id;

    vga_plot_arbiter #(.NUM_CLIENTS(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .TIMEOUT(TO)) dut (
        .CLOCK_50(clk), .resetn(rstn), .req_valid(req_valid), .req_last(req_last),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_ready(req_ready),
        .burst_done(burst_done), .screenX(screenX), .screenY(screenY), .colour(colour),
        .plotWriteEnable(plot), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef logic [42:0] pix_t;   // {client, x, y, colour}
    typedef struct {
        logic [3:0]  v, l;
        logic [7:0]  x;
        logic [3:0]  e_ready, e_done;
        logic        e_plot, e_busy;
        logic [7:0]  e_x, e_y;
        logic [23:0] e_col;
    } vec_t;

    pix_t sb[$];
    pix_t obs[$];
    int   obs_cyc[$];
    int   cyc = 0;
    int   done_cnt[N];
    int   snap[N];
    int   tests = 0, fails = 0;
    int   c_k[N], c_tot[N], c_len[N], c_bub_at[N], c_bub_len[N], c_hold[N];
    vec_t tv[6];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every plotted pixel and every burst_done pulse
    always @(negedge clk) begin
        if (rstn) begin
            if (plot) begin
                obs.push_back({grant_id, screenX, screenY, colour});
                obs_cyc.push_back(cyc);
            end
            for (int i = 0; i < N; i++) begin
                if (burst_done[i]) done_cnt[i] <= done_cnt[i] + 1;
            end
        end
    end

    function automatic pix_t pix(int i, int k);
        logic [7:0]  x, y;
        logic [23:0] c;
        x = 8'(10 + 40 * i + k);
        y = 8'(60 + i);
        c = {8'(i * 50 + 5), 8'(k), 8'(255 - k)};
        return {3'(i), x, y, c};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        pix_t p;
        logic act;
        for (int i = 0; i < N; i++) begin
            act = (c_k[i] < c_tot[i]) && (c_hold[i] == 0);
            p = pix(i, c_k[i]);
            req_valid[i] = act;
            req_last[i]  = act && (((c_k[i] + 1) % c_len[i]) == 0);
            req_x[i*XW +: XW]      = p[39:32];
            req_y[i*YW +: YW]      = p[31:24];
            req_colour[i*CW +: CW] = p[23:0];
        end
    endtask

    task automatic bfm_clear();
        for (int i = 0; i < N; i++) begin
            c_k[i] = 0; c_tot[i] = 0; c_len[i] = 1;
            c_bub_at[i] = -1; c_bub_len[i] = 0; c_hold[i] = 0;
        end
        drive();
    endtask

    task automatic start(int i, int len, int tot, int bat, int blen);
        c_k[i] = 0; c_len[i] = len; c_tot[i] = tot;
        c_bub_at[i] = bat; c_bub_len[i] = blen; c_hold[i] = 0;
        drive();
    endtask

    task automatic push(int i, int k0, int n);
        for (int k = k0; k < k0 + n; k++) sb.push_back(pix(i, k));
    endtask

    // One clock of the client models: advance on handshake, honour scripted bubbles
    task automatic step();
        logic [N-1:0] acc;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (c_hold[i] > 0) begin
                c_hold[i]--;
            end else if (acc[i]) begin
                if (c_k[i] == c_bub_at[i]) c_hold[i] = c_bub_len[i];
                c_k[i]++;
            end
        end
        drive();
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) if (c_k[i] < c_tot[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run(string nm, int max);
        int n = 0;
        while (!all_done() && n < max) begin
            step();
            n++;
        end
        chk({nm, "_complete"}, 64'(all_done()), 64'd1);
        repeat (3) step();
    endtask

    task automatic drain(string nm);
        pix_t e, a;
        int   idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s_px%0d: no plot seen, expected %0h", nm, idx, e);
            end else begin
                a = obs.pop_front();
                chk($sformatf("%s_px%0d", nm, idx), 64'(a), 64'(e));
            end
            idx++;
        end
        chk({nm, "_extra_plots"}, 64'(obs.size()), 64'd0);
        obs.delete();
    endtask

    task automatic span(string nm, int exp);
        chk(nm, 64'(obs_cyc.size() > 0 ? obs_cyc[$] - obs_cyc[0] : -1), 64'(exp));
    endtask

    task automatic take_snap();
        for (int i = 0; i < N; i++) snap[i] = done_cnt[i];
    endtask

    function automatic logic [31:0] dd();
        return {8'(done_cnt[3] - snap[3]), 8'(done_cnt[2] - snap[2]),
                8'(done_cnt[1] - snap[1]), 8'(done_cnt[0] - snap[0])};
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        bfm_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs.delete();
        obs_cyc.delete();
        sb.delete();
        rstn = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tv[0] = '{v:4'b0010, l:4'b0000, x:8'd10, e_ready:4'b0010, e_done:4'b0000, e_plot:1'b0, e_busy:1'b1, e_x:8'd0,  e_y:8'd0,  e_col:24'h000000};
        tv[1] = '{v:4'b0010, l:4'b0000, x:8'd10, e_ready:4'b0010, e_done:4'b0000, e_plot:1'b1, e_busy:1'b1, e_x:8'd10, e_y:8'd20, e_col:24'hFF0000};
        tv[2] = '{v:4'b0010, l:4'b0000, x:8'd11, e_ready:4'b0010, e_done:4'b0000, e_plot:1'b1, e_busy:1'b1, e_x:8'd11, e_y:8'd20, e_col:24'hFF0000};
        tv[3] = '{v:4'b0010, l:4'b0000, x:8'd12, e_ready:4'b0010, e_done:4'b0000, e_plot:1'b1, e_busy:1'b1, e_x:8'd12, e_y:8'd20, e_col:24'hFF0000};
        tv[4] = '{v:4'b0010, l:4'b0010, x:8'd13, e_ready:4'b0000, e_done:4'b0010, e_plot:1'b1, e_busy:1'b0, e_x:8'd13, e_y:8'd20, e_col:24'hFF0000};
        tv[5] = '{v:4'b0000, l:4'b0000, x:8'd99, e_ready:4'b0000, e_done:4'b0000, e_plot:1'b0, e_busy:1'b0, e_x:8'd13, e_y:8'd20, e_col:24'hFF0000};

        bfm_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'({req_ready, burst_done, plot, busy, grant_id, screenX, screenY, colour}), 64'd0);

        // Single burst from client 1, one vector per clock
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = tv[i].v;
            req_last  = tv[i].l;
            req_x[15:8]       = tv[i].x;
            req_y[15:8]       = 8'd20;
            req_colour[47:24] = 24'hFF0000;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                64'({req_ready, burst_done, plot, busy, screenX, screenY, colour}),
                64'({tv[i].e_ready, tv[i].e_done, tv[i].e_plot, tv[i].e_busy, tv[i].e_x, tv[i].e_y, tv[i].e_col}));
        end
        chk("vec_grant_id", 64'(grant_id), 64'd1);

        // Contention: 0, 2, 3 together -> served 0, 2, 3 with one idle clock between bursts
        do_reset();
        take_snap();
        start(0, 2, 2, -1, 0);
        start(2, 2, 2, -1, 0);
        start(3, 2, 2, -1, 0);
        push(0, 0, 2); push(2, 0, 2); push(3, 0, 2);
        run("contention", 200);
        span("contention_span", 7);
        drain("contention");
        chk("contention_done", 64'(dd()), 64'h01010001);

        // Fairness: client 0 re-requests at once, pending client 3 goes first
        do_reset();
        take_snap();
        start(0, 2, 4, -1, 0);
        start(3, 2, 2, -1, 0);
        push(0, 0, 2); push(3, 0, 2); push(0, 2, 2);
        run("fairness", 200);
        span("fairness_span", 7);
        drain("fairness");
        chk("fairness_done", 64'(dd()), 64'h01000002);

        // Bubble: client 2 drops valid for 3 clocks after its second pixel
        do_reset();
        take_snap();
        start(2, 4, 4, 1, 3);
        push(2, 0, 4);
        run("bubble", 200);
        span("bubble_span", 6);
        drain("bubble");
        chk("bubble_done", 64'(dd()), 64'h00010000);

        // Reset mid-burst after 2 of 5 pixels, then client 0 beats client 1
        do_reset();
        take_snap();
        start(2, 5, 5, -1, 0);
        push(2, 0, 2);
        n = 0;
        while (c_k[2] < 2 && n < 50) begin
            step();
            n++;
        end
        chk("rst_two_accepted", 64'(c_k[2]), 64'd2);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_async_outputs", 64'({req_ready, burst_done, plot, busy, grant_id, screenX, screenY, colour}), 64'd0);
        drain("rst_pre");
        bfm_clear();
        start(0, 1, 1, -1, 0);
        start(1, 1, 1, -1, 0);
        push(0, 0, 1); push(1, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        run("rst_after", 50);
        drain("rst_after");
        chk("rst_done", 64'(dd()), 64'h00000101);

        // Stall: client 0 stops after its first pixel while client 1 waits
        do_reset();
        take_snap();
        start(0, 3, 3, 0, STALL);
        start(1, 2, 2, -1, 0);
`ifdef PLOT_ARB_TIMEOUT_EN
        push(0, 0, 1); push(1, 0, 2); push(0, 1, 2);
`else
        push(0, 0, 3); push(1, 0, 2);
`endif
        n = 0;
        while (c_k[0] < 1 && n < 20) begin
            step();
            n++;
        end
`ifdef PLOT_ARB_TIMEOUT_EN
        repeat (10) step();
        chk("timeout_regrant", 64'({req_ready, busy}), 64'({4'b0010, 1'b1}));
`else
        repeat (STALL - 5) step();
        chk("stall_hold", 64'({req_ready, busy}), 64'({4'b0001, 1'b1}));
`endif
        run("stall", 2000);
        drain("stall");
        chk("stall_done", 64'(dd()), 64'h00000101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
